// File: rtl/mips_mem_pkg.sv
// ---------------------------------------------------------------------------
// mips_mem_pkg
// Shared definitions for the data memory block.
//   mem_state_e   : controller states (INIT = clear sweep, READY = serving)
//   DEPTH_DEFAULT : default number of 32-bit words
//   COUNT_MAX     : value at which the access counters stop
// ---------------------------------------------------------------------------
package mips_mem_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } mem_state_e;

    localparam int          DEPTH_DEFAULT = 256;
    localparam logic [15:0] COUNT_MAX     = 16'hFFFF;

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// 16-bit up counter that stops at COUNT_MAX instead of wrapping.
// Ports:
//   clk_i   : rising-edge clock
//   clr_i   : synchronous clear, has priority over en_i
//   en_i    : count one step at the next edge
//   count_o : current count
// ---------------------------------------------------------------------------
module sat_counter
    import mips_mem_pkg::*;
(
    input  logic        clk_i,
    input  logic        clr_i,
    input  logic        en_i,
    output logic [15:0] count_o
);

    logic [15:0] count_q;
    logic [15:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en_i && (count_q != COUNT_MAX)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/data_mem.sv
// ---------------------------------------------------------------------------
// data_mem
// Word-addressed 32-bit data memory for a processor, with a post-reset clear
// sweep, sticky access-error flags and saturating access counters.
//
// Request semantics: mem_read and mem_write are level requests with no
// handshake back. A request is accepted in any cycle where the controller is
// READY and the byte address is word aligned and inside the array. Read data
// is combinational in the same cycle; write data commits at the next rising
// edge. Rejected or INIT-time requests never touch the array; in READY a
// rejected request sets the matching sticky flag(s).
//
// Ports:
//   clk            : rising-edge clock
//   rst            : synchronous active-high reset
//   data_adr       : byte address
//   data_out       : write data from the processor
//   data_in        : read data to the processor (0 unless a valid read)
//   mem_read       : read request
//   mem_write      : write request
//   init_busy      : high while the clear sweep runs
//   err_misaligned : sticky, an access used data_adr[1:0] != 0
//   err_range      : sticky, an access used data_adr >= DEPTH*4
//   rd_count       : accepted reads, saturating
//   wr_count       : accepted writes, saturating
//   dbg_state_o    : controller state (0 = INIT, 1 = READY)
// ---------------------------------------------------------------------------
module data_mem
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_adr,
    input  logic [31:0] data_out,
    output logic [31:0] data_in,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic        init_busy,
    output logic        err_misaligned,
    output logic        err_range,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count,
    output logic        dbg_state_o
);

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    mem_state_e    state_q;
    mem_state_e    state_d;
    logic [AW-1:0] idx_q;
    logic [AW-1:0] idx_d;
    logic          sweep_we;

    logic [31:0]   mem_q [DEPTH];

    logic [AW-1:0] word_idx;
    logic          aligned;
    logic          in_range;
    logic          ready;
    logic          access;
    logic          rd_valid;
    logic          wr_valid;

    logic          err_mis_q;
    logic          err_mis_d;
    logic          err_rng_q;
    logic          err_rng_d;

    // -----------------------------------------------------------------------
    // Address decode
    // -----------------------------------------------------------------------
    assign word_idx = data_adr[AW+1:2];
    assign aligned  = (data_adr[1:0] == 2'b00);
    // Any set bit above the word index means the byte address is past the end.
    assign in_range = (data_adr[31:AW+2] == '0);
    assign ready    = (state_q == READY);
    assign access   = mem_read | mem_write;
    assign rd_valid = mem_read  & ready & aligned & in_range;
    assign wr_valid = mem_write & ready & aligned & in_range;

    // -----------------------------------------------------------------------
    // Controller: INIT clears one word per cycle, then READY forever
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        sweep_we = 1'b0;
        case (state_q)
            INIT: begin
                sweep_we = 1'b1;
                idx_d    = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = READY;
                end
            end
            READY: begin
                state_d = READY;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // -----------------------------------------------------------------------
    // Storage. Not reset directly; the sweep clears it. A write presented in
    // the same cycle as rst is dropped.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (sweep_we) begin
                mem_q[idx_q] <= '0;
            end else if (wr_valid) begin
                mem_q[word_idx] <= data_out;
            end
        end
    end

    // Read returns the pre-edge word, so a same-cycle write shows up next cycle.
    assign data_in = rd_valid ? mem_q[word_idx] : 32'h0;

    // -----------------------------------------------------------------------
    // Sticky error flags
    // -----------------------------------------------------------------------
    always_comb begin
        err_mis_d = err_mis_q | (ready & access & ~aligned);
        err_rng_d = err_rng_q | (ready & access & ~in_range);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_mis_q <= 1'b0;
            err_rng_q <= 1'b0;
        end else begin
            err_mis_q <= err_mis_d;
            err_rng_q <= err_rng_d;
        end
    end

    // -----------------------------------------------------------------------
    // Access counters
    // -----------------------------------------------------------------------
    sat_counter u_rd_count (
        .clk_i   (clk),
        .clr_i   (rst),
        .en_i    (rd_valid),
        .count_o (rd_count)
    );

    sat_counter u_wr_count (
        .clk_i   (clk),
        .clr_i   (rst),
        .en_i    (wr_valid),
        .count_o (wr_count)
    );

    assign init_busy      = (state_q == INIT);
    assign err_misaligned = err_mis_q;
    assign err_range      = err_rng_q;
    assign dbg_state_o    = state_q;

endmodule
